// File: rtl/t09_obstacle_pkg.sv
// Shared types and grid limits for the obstacle spawner and its table.
package t09_obstacle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_CAPTURE,
        S_Q1,
        S_C1,
        S_Q2,
        S_C2,
        S_COMMIT
    } state_t;

    localparam logic [3:0] GRID_X_MIN = 4'd1;
    localparam logic [3:0] GRID_X_MAX = 4'd14;
    localparam logic [3:0] GRID_Y_MIN = 4'd1;
    localparam logic [3:0] GRID_Y_MAX = 4'd10;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    // True when the cell lies strictly inside the border walls.
    function automatic logic inGrid(coord_t c);
        return (c.x >= GRID_X_MIN) && (c.x <= GRID_X_MAX) &&
               (c.y >= GRID_Y_MIN) && (c.y <= GRID_Y_MAX);
    endfunction

endpackage

// File: rtl/t09_obstacle_table.sv
// Obstacle cell storage: two-entry write at the fill level, one
// combinational read port, and a match of one cell against live entries.
module t09_obstacle_table
    import t09_obstacle_pkg::*;
#(
    parameter int MAX_OBS = 8,
    localparam int CW = $clog2(MAX_OBS + 1),
    localparam int IW = $clog2(MAX_OBS)
)(
    input  logic          i_clk,
    input  logic          i_nRst,
    input  logic          i_wrEn,
    input  coord_t        i_wrCell0,
    input  coord_t        i_wrCell1,
    input  logic [CW-1:0] i_count,
    input  logic [IW-1:0] i_rdIdx,
    output coord_t        o_rdCell,
    input  coord_t        i_matchCell,
    output logic          o_match
);

    coord_t r_table [MAX_OBS];
    logic   w_match;

    // Write the committed pair into the two slots just above the fill level.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            for (int i = 0; i < MAX_OBS; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wrEn) begin
            for (int i = 0; i < MAX_OBS; i++) begin
                if (CW'(i) == i_count) begin
                    r_table[i] <= i_wrCell0;
                end else if (CW'(i) == i_count + CW'(1)) begin
                    r_table[i] <= i_wrCell1;
                end
            end
        end
    end

    // Stale entries above the fill level are ignored so a clear needs no wipe.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < MAX_OBS; i++) begin
            if ((CW'(i) < i_count) && (r_table[i] == i_matchCell)) begin
                w_match = 1'b1;
            end
        end
    end

    assign o_rdCell = r_table[i_rdIdx];
    assign o_match  = w_match;

endmodule

// File: rtl/t09_obstacle_spawner.sv
// Spawn controller: advances the coordinate generator, validates a
// candidate pair against walls, occupancy and existing obstacles, retries
// up to MAX_TRIES times and commits accepted pairs to the obstacle table.
module t09_obstacle_spawner
    import t09_obstacle_pkg::*;
#(
    parameter int MAX_OBS   = 8,
    parameter int MAX_TRIES = 4,
    localparam int CW = $clog2(MAX_OBS + 1),
    localparam int IW = $clog2(MAX_OBS),
    localparam int TW = $clog2(MAX_TRIES + 1)
)(
    input  logic          i_clk,
    input  logic          i_nRst,
    input  logic          i_spawnReq,
    input  logic          i_clearAll,
    input  logic [3:0]    i_randX,
    input  logic [3:0]    i_randY,
    input  logic [3:0]    i_randX2,
    input  logic [3:0]    i_randY2,
    output logic          o_obstacleFlag,
    output logic          o_qValid,
    output logic [3:0]    o_qX,
    output logic [3:0]    o_qY,
    input  logic          i_qOccupied,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_fail,
    output logic [CW-1:0] o_obsCount,
    input  logic [IW-1:0] i_rdIdx,
    output logic [3:0]    o_rdX,
    output logic [3:0]    o_rdY,
    output logic          o_rdValid
);

    state_t        r_state;
    logic [CW-1:0] r_obsCount;
    logic [TW-1:0] r_tries;
    coord_t        r_cand1;
    coord_t        r_cand2;
    logic          r_obstacleFlag;
    logic          r_qValid;
    logic [3:0]    r_qX;
    logic [3:0]    r_qY;
    logic          r_busy;
    logic          r_done;
    logic          r_fail;

    coord_t        w_checkCell;
    logic          w_match;
    logic          w_reject;
    logic          w_commit;
    coord_t        w_rdCell;

    // Pick the candidate under test and decide whether it must be thrown away.
    always_comb begin
        w_checkCell = (r_state == S_C2) ? r_cand2 : r_cand1;
        w_reject    = i_qOccupied || !inGrid(w_checkCell) || w_match ||
                      ((r_state == S_C2) && (r_cand2 == r_cand1));
    end

    assign w_commit = (r_state == S_COMMIT) && i_nRst && !i_clearAll;

    t09_obstacle_table #(
        .MAX_OBS (MAX_OBS)
    ) u_table (
        .i_clk       (i_clk),
        .i_nRst      (i_nRst),
        .i_wrEn      (w_commit),
        .i_wrCell0   (r_cand1),
        .i_wrCell1   (r_cand2),
        .i_count     (r_obsCount),
        .i_rdIdx     (i_rdIdx),
        .o_rdCell    (w_rdCell),
        .i_matchCell (w_checkCell),
        .o_match     (w_match)
    );

    // Spawn FSM; each output register is loaded with the value of the state being entered.
    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            r_state        <= S_IDLE;
            r_obsCount     <= '0;
            r_tries        <= '0;
            r_cand1        <= '0;
            r_cand2        <= '0;
            r_obstacleFlag <= 1'b0;
            r_qValid       <= 1'b0;
            r_qX           <= '0;
            r_qY           <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
        end else if (i_clearAll) begin
            r_state        <= S_IDLE;
            r_obsCount     <= '0;
            r_tries        <= '0;
            r_obstacleFlag <= 1'b0;
            r_qValid       <= 1'b0;
            r_qX           <= '0;
            r_qY           <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
        end else begin
            r_obstacleFlag <= 1'b0;
            r_qValid       <= 1'b0;
            r_qX           <= '0;
            r_qY           <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (i_spawnReq) begin
                        if (r_obsCount > CW'(MAX_OBS - 2)) begin
                            r_fail <= 1'b1;
                        end else begin
                            r_tries        <= '0;
                            r_state        <= S_ADVANCE;
                            r_obstacleFlag <= 1'b1;
                            r_busy         <= 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_cand1  <= '{x: i_randX,  y: i_randY};
                    r_cand2  <= '{x: i_randX2, y: i_randY2};
                    r_state  <= S_Q1;
                    r_qValid <= 1'b1;
                    r_qX     <= i_randX;
                    r_qY     <= i_randY;
                end
                S_Q1: begin
                    r_state <= S_C1;
                end
                S_C1, S_C2: begin
                    if (w_reject) begin
                        r_tries <= r_tries + TW'(1);
                        if (r_tries + TW'(1) == TW'(MAX_TRIES)) begin
                            r_state <= S_IDLE;
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state        <= S_ADVANCE;
                            r_obstacleFlag <= 1'b1;
                        end
                    end else if (r_state == S_C1) begin
                        r_state  <= S_Q2;
                        r_qValid <= 1'b1;
                        r_qX     <= r_cand2.x;
                        r_qY     <= r_cand2.y;
                    end else begin
                        r_state <= S_COMMIT;
                        r_done  <= 1'b1;
                    end
                end
                S_Q2: begin
                    r_state <= S_C2;
                end
                S_COMMIT: begin
                    r_obsCount <= r_obsCount + CW'(2);
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_obstacleFlag = r_obstacleFlag;
    assign o_qValid       = r_qValid;
    assign o_qX           = r_qX;
    assign o_qY           = r_qY;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_fail         = r_fail;
    assign o_obsCount     = r_obsCount;
    assign o_rdX          = w_rdCell.x;
    assign o_rdY          = w_rdCell.y;
    assign o_rdValid      = CW'(i_rdIdx) < r_obsCount;

endmodule
